// File: rtl/uart_arb_pkg.sv
// Shared definitions for uart_tx_arbiter: FSM state encoding, index-width helper and gap counter width.
package uart_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_WRITE = WRITE,
        ST_GAP   = GAP
    } arb_state_t;

    localparam int GAP_CNT_W = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority encoder: first set bit of valid strictly after ptr, wrapping, ptr itself searched last.
// Purely combinational, no backpressure of its own.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        win = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && valid[j]) begin
                any    = 1'b1;
                win[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of the uart Avalon write port; grant in IDLE, avalon_write next cycle, held while waitrequest.
// GAP idle cycles between writes; UART_ARB_LOCK_EN adds req_last packet locking to the granted requester.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  N_REQ = 4,
    parameter int  DW    = 8,
    parameter int  GAP   = 0,
    localparam int IW    = clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
`ifdef UART_ARB_LOCK_EN
    input  logic [N_REQ-1:0]    req_last,
`endif
    output logic                avalon_write,
    output logic [DW-1:0]       avalon_writedata,
    input  logic                avalon_waitrequest,
    output logic [IW-1:0]       grant_id,
    output logic                busy
);

    localparam logic [GAP_CNT_W-1:0] GAP_LD = GAP_CNT_W'(GAP);

    arb_state_t           state;
    logic [IW-1:0]        ptr;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic [N_REQ-1:0]     elig;
    logic [N_REQ-1:0]     win;
    logic [IW-1:0]        win_idx;
    logic                 win_any;

`ifdef UART_ARB_LOCK_EN
    logic lock;

    // ptr always holds the last granted requester, i.e. the lock owner
    always_comb begin
        elig = req_valid;
        if (lock) elig = req_valid & (N_REQ'(1) << ptr);
    end
`else
    assign elig = req_valid;
`endif

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .valid (elig),
        .ptr   (ptr),
        .win   (win),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign req_ready = (state == ST_IDLE) ? win : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            avalon_write     <= 1'b0;
            avalon_writedata <= '0;
            grant_id         <= '0;
            busy             <= 1'b0;
            ptr              <= IW'(N_REQ - 1);
            gap_cnt          <= '0;
`ifdef UART_ARB_LOCK_EN
            lock             <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        avalon_writedata <= req_data[win_idx*DW +: DW];
                        grant_id         <= win_idx;
                        ptr              <= win_idx;
                        avalon_write     <= 1'b1;
                        busy             <= 1'b1;
                        state            <= ST_WRITE;
`ifdef UART_ARB_LOCK_EN
                        lock             <= !req_last[win_idx];
`endif
                    end
                end
                ST_WRITE: begin
                    if (!avalon_waitrequest) begin
                        avalon_write <= 1'b0;
                        if (GAP > 0) begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_LD;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_CNT_W'(1)) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_CNT_W'(1);
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    avalon_write <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
